// File: rtl/multicycle_sequencer_pkg.sv
// rtl/multicycle_sequencer_pkg.sv - opcode constants and state encoding for the multicycle sequencer
package multicycle_sequencer_pkg;

    // Opcodes 0..2 are ALU operations; everything below routes control flow or memory.
    localparam logic [2:0] kLD   = 3'd3;
    localparam logic [2:0] kST   = 3'd4;
    localparam logic [2:0] kBRE  = 3'd5;
    localparam logic [2:0] kJ    = 3'd6;
    localparam logic [2:0] kHALT = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        MEM,
        WB,
        HALT
    } seq_state_t;

    function automatic logic [2:0] op_of(input logic [8:0] instr);
        return instr[8:6];
    endfunction

endpackage

// File: rtl/branch_target_lut.sv
// rtl/branch_target_lut.sv - writable table of absolute jump/branch targets
module branch_target_lut #(
    parameter int LUT_DEPTH = 32,
    parameter int ADDR_W    = 5,
    parameter int PC_W      = 10
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PC_W-1:0]   wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PC_W-1:0]   rd_data
);

    logic [PC_W-1:0] entries [LUT_DEPTH];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (wr_en) begin
            entries[wr_addr] <= wr_data;
        end
    end

    // Asynchronous read sees the pre-write value during a same-cycle write.
    assign rd_data = entries[rd_addr];

endmodule

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multi-cycle FETCH/EXEC/MEM/WB control sequencer
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int PC_W      = 10,
    parameter int LUT_DEPTH = 32,
    parameter int CNT_W     = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [8:0]       Instruction,
    input  logic             ZERO,
    input  logic             MemAck,
    input  logic             LutWrEn,
    input  logic [4:0]       LutAddr,
    input  logic [PC_W-1:0]  LutData,
    output logic [PC_W-1:0]  PC,
    output logic [8:0]       IR,
    output logic             MemRdEn,
    output logic             MemWrEn,
    output logic             RegWrEn,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    seq_state_t       state, state_nxt;
    logic [PC_W-1:0]  pc_q, pc_nxt, pc_inc, lut_target;
    logic [8:0]       ir_q, ir_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [2:0]       op;
    logic             busy;

    branch_target_lut #(
        .LUT_DEPTH (LUT_DEPTH),
        .ADDR_W    (5),
        .PC_W      (PC_W)
    ) u_lut (
        .Clk     (Clk),
        .Reset   (Reset),
        .wr_en   (LutWrEn),
        .wr_addr (LutAddr),
        .wr_data (LutData),
        .rd_addr (ir_q[4:0]),
        .rd_data (lut_target)
    );

    assign op     = op_of(ir_q);
    assign pc_inc = pc_q + PC_W'(1);
    assign busy   = (state == FETCH) || (state == EXEC) || (state == MEM) || (state == WB);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            pc_q  <= '0;
            ir_q  <= '0;
            cnt_q <= '0;
        end else begin
            state <= state_nxt;
            pc_q  <= pc_nxt;
            ir_q  <= ir_nxt;
            cnt_q <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        ir_nxt    = ir_q;
        cnt_nxt   = cnt_q;

        if (busy && (cnt_q != CNT_MAX)) begin
            cnt_nxt = cnt_q + CNT_W'(1);
        end

        case (state)
            IDLE, HALT: begin
                if (Start) begin
                    state_nxt = FETCH;
                    pc_nxt    = '0;
                    cnt_nxt   = '0;
                end
            end
            FETCH: begin
                ir_nxt    = Instruction;
                state_nxt = EXEC;
            end
            EXEC: begin
                case (op)
                    kJ: begin
                        pc_nxt    = lut_target;
                        state_nxt = FETCH;
                    end
                    kBRE: begin
                        pc_nxt    = ZERO ? lut_target : pc_inc;
                        state_nxt = FETCH;
                    end
                    kHALT:   state_nxt = HALT;
                    kLD, kST: state_nxt = MEM;
                    default: state_nxt = WB;
                endcase
            end
            MEM: begin
                if (MemAck) begin
                    if (op == kLD) begin
                        state_nxt = WB;
                    end else begin
                        pc_nxt    = pc_inc;
                        state_nxt = FETCH;
                    end
                end
            end
            WB: begin
                pc_nxt    = pc_inc;
                state_nxt = FETCH;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign PC       = pc_q;
    assign IR       = ir_q;
    assign Busy     = busy;
    assign Done     = (state == HALT);
    assign RegWrEn  = (state == WB);
    assign MemRdEn  = (state == MEM) && (op == kLD);
    assign MemWrEn  = (state == MEM) && (op == kST);
    assign CycleCnt = cnt_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - self-checking bench for multicycle_sequencer
module tb_multicycle_sequencer;
    import multicycle_sequencer_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic        ZERO = 1'b0;
    logic        MemAck = 1'b0;
    logic        LutWrEn = 1'b0;
    logic [4:0]  LutAddr = '0;
    logic [9:0]  LutData = '0;
    logic [8:0]  Instruction, Instruction_s;
    logic [9:0]  PC, PC_s;
    logic [8:0]  IR, IR_s;
    logic        MemRdEn, MemWrEn, RegWrEn, Busy, Done;
    logic        MemRdEn_s, MemWrEn_s, RegWrEn_s, Busy_s, Done_s;
    logic [15:0] CycleCnt;
    logic [3:0]  CycleCnt_s;

    logic [8:0] rom [1024];

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       rw;
        logic       rd;
        logic       wr;
        logic [9:0] pc;
    } obs_t;

    obs_t exp_q[$];
    obs_t got, exp_v;

    always #5 Clk = ~Clk;

    assign Instruction   = rom[PC];
    assign Instruction_s = rom[PC_s];

    multicycle_sequencer dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Instruction(Instruction),
        .ZERO(ZERO), .MemAck(MemAck), .LutWrEn(LutWrEn), .LutAddr(LutAddr),
        .LutData(LutData), .PC(PC), .IR(IR), .MemRdEn(MemRdEn), .MemWrEn(MemWrEn),
        .RegWrEn(RegWrEn), .Busy(Busy), .Done(Done), .CycleCnt(CycleCnt)
    );

    multicycle_sequencer #(.CNT_W(4)) dut_s (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Instruction(Instruction_s),
        .ZERO(ZERO), .MemAck(MemAck), .LutWrEn(LutWrEn), .LutAddr(LutAddr),
        .LutData(LutData), .PC(PC_s), .IR(IR_s), .MemRdEn(MemRdEn_s), .MemWrEn(MemWrEn_s),
        .RegWrEn(RegWrEn_s), .Busy(Busy_s), .Done(Done_s), .CycleCnt(CycleCnt_s)
    );

    function automatic obs_t mk(input logic b, input logic d, input logic rw,
                                input logic rd, input logic wr, input logic [9:0] pc);
        return {b, d, rw, rd, wr, pc};
    endfunction

    // FETCH and EXEC look identical on the outputs.
    function automatic obs_t fe(input logic [9:0] pc); return mk(1, 0, 0, 0, 0, pc); endfunction
    function automatic obs_t wb(input logic [9:0] pc); return mk(1, 0, 1, 0, 0, pc); endfunction
    function automatic obs_t mr(input logic [9:0] pc); return mk(1, 0, 0, 1, 0, pc); endfunction
    function automatic obs_t mw(input logic [9:0] pc); return mk(1, 0, 0, 0, 1, pc); endfunction
    function automatic obs_t hl(input logic [9:0] pc); return mk(0, 1, 0, 0, 0, pc); endfunction

    function automatic obs_t observe();
        return {Busy, Done, RegWrEn, MemRdEn, MemWrEn, PC};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 1024; i++) rom[i] = {kHALT, 6'd0};
    endtask

    task automatic do_reset();
        Reset = 1'b1; Start = 1'b0; LutWrEn = 1'b0; MemAck = 1'b0; ZERO = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic lut_write(input logic [4:0] a, input logic [9:0] d);
        LutWrEn = 1'b1; LutAddr = a; LutData = d;
        @(negedge Clk);
        LutWrEn = 1'b0;
    endtask

    task automatic test_reset();
        clear_rom();
        Reset = 1'b1; Start = 1'b1; MemAck = 1'b1;
        @(negedge Clk);
        Reset = 1'b0; Start = 1'b0; MemAck = 1'b0;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 10'h000));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 10'h000));
        for (int i = 0; exp_q.size() > 0; i++) begin
            got = observe(); exp_v = exp_q.pop_front(); checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL reset_state cyc %0d got %h exp %h", i, got, exp_v);
            end
            @(negedge Clk);
        end
        checks++;
        if (IR !== 9'h000 || CycleCnt !== 16'h0000) begin
            errors++; $display("FAIL reset_ir_cnt got IR %h cnt %0d exp 0 0", IR, CycleCnt);
        end
    endtask

    task automatic test_alu();
        clear_rom(); do_reset();
        rom[0] = {3'd1, 6'h12};
        exp_q.push_back(fe(0)); exp_q.push_back(fe(0)); exp_q.push_back(wb(0));
        exp_q.push_back(fe(1)); exp_q.push_back(fe(1)); exp_q.push_back(hl(1));
        pulse_start();
        for (int i = 0; exp_q.size() > 0; i++) begin
            got = observe(); exp_v = exp_q.pop_front(); checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL alu_trace cyc %0d got %h exp %h", i, got, exp_v);
            end
            if (i == 1) begin
                checks++;
                if (IR !== 9'h052) begin
                    errors++; $display("FAIL alu_ir got %h exp 052", IR);
                end
            end
            @(negedge Clk);
        end
        checks++;
        if (CycleCnt !== 16'd5) begin
            errors++; $display("FAIL alu_cnt got %0d exp 5", CycleCnt);
        end
    endtask

    task automatic test_branch();
        clear_rom(); do_reset();
        lut_write(5'd3, 10'h040);
        rom[0] = {kBRE, 6'd3};
        ZERO = 1'b1;
        exp_q.push_back(fe(0)); exp_q.push_back(fe(0));
        exp_q.push_back(fe(10'h040)); exp_q.push_back(fe(10'h040)); exp_q.push_back(hl(10'h040));
        pulse_start();
        for (int i = 0; exp_q.size() > 0; i++) begin
            got = observe(); exp_v = exp_q.pop_front(); checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL br_taken cyc %0d got %h exp %h", i, got, exp_v);
            end
            @(negedge Clk);
        end
        ZERO = 1'b0;
        exp_q.push_back(fe(0)); exp_q.push_back(fe(0));
        exp_q.push_back(fe(1)); exp_q.push_back(fe(1)); exp_q.push_back(hl(1));
        pulse_start();
        for (int i = 0; exp_q.size() > 0; i++) begin
            got = observe(); exp_v = exp_q.pop_front(); checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL br_not_taken cyc %0d got %h exp %h", i, got, exp_v);
            end
            if (i == 0) begin
                checks++;
                if (CycleCnt !== 16'd0) begin
                    errors++; $display("FAIL restart_cnt got %0d exp 0", CycleCnt);
                end
            end
            @(negedge Clk);
        end
        checks++;
        if (CycleCnt !== 16'd4) begin
            errors++; $display("FAIL br_cnt got %0d exp 4", CycleCnt);
        end
    endtask

    task automatic test_load_store();
        clear_rom(); do_reset();
        rom[0] = {kLD, 6'd0};
        exp_q.push_back(fe(0)); exp_q.push_back(fe(0));
        for (int k = 0; k < 4; k++) exp_q.push_back(mr(0));
        exp_q.push_back(wb(0)); exp_q.push_back(fe(1)); exp_q.push_back(fe(1)); exp_q.push_back(hl(1));
        pulse_start();
        for (int i = 0; exp_q.size() > 0; i++) begin
            got = observe(); exp_v = exp_q.pop_front(); checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL load_trace cyc %0d got %h exp %h", i, got, exp_v);
            end
            MemAck = (i <= 1) || (i == 5);
            @(negedge Clk);
        end
        MemAck = 1'b0;
        checks++;
        if (CycleCnt !== 16'd9) begin
            errors++; $display("FAIL load_cnt got %0d exp 9", CycleCnt);
        end

        clear_rom(); do_reset();
        rom[0] = {kST, 6'd0};
        exp_q.push_back(fe(0)); exp_q.push_back(fe(0)); exp_q.push_back(mw(0)); exp_q.push_back(mw(0));
        exp_q.push_back(fe(1)); exp_q.push_back(fe(1)); exp_q.push_back(hl(1));
        pulse_start();
        for (int i = 0; exp_q.size() > 0; i++) begin
            got = observe(); exp_v = exp_q.pop_front(); checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL store_trace cyc %0d got %h exp %h", i, got, exp_v);
            end
            MemAck = (i <= 1) || (i == 3);
            @(negedge Clk);
        end
        MemAck = 1'b0;
        checks++;
        if (CycleCnt !== 16'd6) begin
            errors++; $display("FAIL store_cnt got %0d exp 6", CycleCnt);
        end
    endtask

    task automatic test_wrap_hazard();
        clear_rom(); do_reset();
        lut_write(5'd2, 10'h3FF);
        rom[0] = {kJ, 6'd2};
        rom[10'h3FF] = {3'd2, 6'h01};
        exp_q.push_back(fe(0)); exp_q.push_back(fe(0));
        exp_q.push_back(fe(10'h3FF)); exp_q.push_back(fe(10'h3FF)); exp_q.push_back(wb(10'h3FF));
        exp_q.push_back(fe(0));
        pulse_start();
        for (int i = 0; exp_q.size() > 0; i++) begin
            got = observe(); exp_v = exp_q.pop_front(); checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL pc_wrap cyc %0d got %h exp %h", i, got, exp_v);
            end
            @(negedge Clk);
        end

        clear_rom(); do_reset();
        lut_write(5'd5, 10'h010);
        rom[0] = {kJ, 6'd5};
        rom[10'h010] = {kJ, 6'd5};
        exp_q.push_back(fe(0)); exp_q.push_back(fe(0));
        exp_q.push_back(fe(10'h010)); exp_q.push_back(fe(10'h010));
        exp_q.push_back(fe(10'h020)); exp_q.push_back(fe(10'h020)); exp_q.push_back(hl(10'h020));
        pulse_start();
        for (int i = 0; exp_q.size() > 0; i++) begin
            got = observe(); exp_v = exp_q.pop_front(); checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL lut_hazard cyc %0d got %h exp %h", i, got, exp_v);
            end
            LutWrEn = (i == 1); LutAddr = 5'd5; LutData = 10'h020;
            @(negedge Clk);
        end
        LutWrEn = 1'b0;
    endtask

    task automatic test_reset_start_robust();
        clear_rom(); do_reset();
        rom[0] = {3'd0, 6'h00};
        rom[1] = {kLD, 6'd0};
        exp_q.push_back(fe(0)); exp_q.push_back(fe(0)); exp_q.push_back(wb(0));
        exp_q.push_back(fe(1)); exp_q.push_back(fe(1)); exp_q.push_back(mr(1));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0)); exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
        pulse_start();
        for (int i = 0; exp_q.size() > 0; i++) begin
            got = observe(); exp_v = exp_q.pop_front(); checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL reset_mid_mem cyc %0d got %h exp %h", i, got, exp_v);
            end
            Reset = (i == 5);
            MemAck = (i == 5);
            @(negedge Clk);
        end
        Reset = 1'b0; MemAck = 1'b0;

        clear_rom();
        rom[0] = {3'd0, 6'h00};
        rom[1] = {3'd1, 6'h00};
        exp_q.push_back(fe(0)); exp_q.push_back(fe(0)); exp_q.push_back(wb(0));
        exp_q.push_back(fe(1)); exp_q.push_back(fe(1)); exp_q.push_back(wb(1));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0)); exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
        pulse_start();
        for (int i = 0; exp_q.size() > 0; i++) begin
            got = observe(); exp_v = exp_q.pop_front(); checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL reset_mid_wb cyc %0d got %h exp %h", i, got, exp_v);
            end
            Reset = (i == 5);
            @(negedge Clk);
        end
        Reset = 1'b0;

        rom[2] = {kHALT, 6'd0};
        exp_q.push_back(fe(0)); exp_q.push_back(fe(0)); exp_q.push_back(wb(0));
        exp_q.push_back(fe(1)); exp_q.push_back(fe(1)); exp_q.push_back(wb(1));
        exp_q.push_back(fe(2)); exp_q.push_back(fe(2)); exp_q.push_back(hl(2));
        pulse_start();
        for (int i = 0; exp_q.size() > 0; i++) begin
            got = observe(); exp_v = exp_q.pop_front(); checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL start_mid_run cyc %0d got %h exp %h", i, got, exp_v);
            end
            Start = (i == 1) || (i == 4);
            @(negedge Clk);
        end
        Start = 1'b0;
        checks++;
        if (CycleCnt !== 16'd8) begin
            errors++; $display("FAIL start_mid_run_cnt got %0d exp 8", CycleCnt);
        end
    endtask

    task automatic test_saturation();
        clear_rom(); do_reset();
        rom[0] = {kJ, 6'd0};
        pulse_start();
        repeat (20) @(negedge Clk);
        checks++;
        if (CycleCnt_s !== 4'd15 || Busy_s !== 1'b1) begin
            errors++; $display("FAIL cnt_saturate got %0d busy %b exp 15 1", CycleCnt_s, Busy_s);
        end
        checks++;
        if (CycleCnt !== 16'd20) begin
            errors++; $display("FAIL cnt_wide got %0d exp 20", CycleCnt);
        end
        do_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        clear_rom();
        @(negedge Clk);
        test_reset();
        test_alu();
        test_branch();
        test_load_store();
        test_wrap_hazard();
        test_reset_start_robust();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
